// File: rtl/sram_bridge_p.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bridge_p
//  Description : Avalon-MM slave to asynchronous SRAM bridge with
//                configurable data/address width, per-lane byte enables,
//                programmable read/write wait states, a read-to-write bus
//                turnaround and a sticky protocol-error flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_clk            : system clock
//    reset_reset_n      : asynchronous active-low reset
//    avs_address        : word address
//    avs_read/avs_write : command strobes (held by master while waitrequest)
//    avs_writedata      : write data
//    avs_byteenable     : write lane enables
//    avs_waitrequest    : command not accepted this cycle
//    avs_readdata       : read data
//    avs_readdatavalid  : single-cycle read data valid pulse
//    sram_addr          : SRAM address
//    sram_dq_in         : DQ pin input
//    sram_dq_out        : DQ drive value
//    sram_dq_oe         : DQ output enable (tristate control for the top)
//    sram_be_n          : active-low lane selects
//    sram_ce_n          : chip enable (active low)
//    sram_oe_n          : output enable (active low)
//    sram_we_n          : write enable (active low)
//    sram_err           : sticky protocol-error flag
// ============================================================================
module sram_bridge_p #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int RD_WAIT     = 1,
  parameter int WR_WAIT     = 1,
  parameter int TURN_CYCLES = 1,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [BE_W-1:0]   avs_byteenable,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic [BE_W-1:0]   sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_RD      = 3'd2,
    S_WR      = 3'd3,
    S_WR_HOLD = 3'd4
  } state_t;

  localparam logic [3:0] c_rd_wait   = 4'(RD_WAIT);
  localparam logic [3:0] c_wr_wait   = 4'(WR_WAIT);
  // The turnaround counter counts down to zero, so it is loaded with N-1.
  localparam logic [3:0] c_turn_init = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;
  localparam logic       c_turn_en   = (TURN_CYCLES > 0);
  localparam logic       c_op_read   = 1'b1;
  localparam logic       c_op_write  = 1'b0;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_last_op, w_last_op_nxt;
  logic [BE_W-1:0]     r_be, w_be_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_dq_out, w_dq_out_nxt;
  logic                r_dq_oe, w_dq_oe_nxt;
  logic [BE_W-1:0]     r_be_n, w_be_n_nxt;
  logic                r_ce_n, w_ce_n_nxt;
  logic                r_oe_n, w_oe_n_nxt;
  logic                r_we_n, w_we_n_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_rvalid, w_rvalid_nxt;
  logic                r_err, w_err_nxt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_last_op <= c_op_write;
      r_be      <= '0;
      r_addr    <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_be_n    <= '1;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last_op <= w_last_op_nxt;
      r_be      <= w_be_nxt;
      r_addr    <= w_addr_nxt;
      r_dq_out  <= w_dq_out_nxt;
      r_dq_oe   <= w_dq_oe_nxt;
      r_be_n    <= w_be_n_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state logic also produces the next value of every registered pin,
  // so each strobe changes on the same edge as the state it belongs to.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_op_nxt = r_last_op;
    w_be_nxt      = r_be;
    w_addr_nxt    = r_addr;
    w_dq_out_nxt  = r_dq_out;
    w_dq_oe_nxt   = r_dq_oe;
    w_be_n_nxt    = r_be_n;
    w_ce_n_nxt    = r_ce_n;
    w_oe_n_nxt    = r_oe_n;
    w_we_n_nxt    = r_we_n;
    w_rdata_nxt   = r_rdata;
    w_rvalid_nxt  = 1'b0;
    w_err_nxt     = r_err;

    case (r_state)
      S_IDLE: begin
        if (avs_read) begin
          // A simultaneous write is dropped and flagged.
          if (avs_write) begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt   = S_RD;
          w_cnt_nxt     = c_rd_wait;
          w_addr_nxt    = avs_address;
          w_last_op_nxt = c_op_read;
          w_ce_n_nxt    = 1'b0;
          w_oe_n_nxt    = 1'b0;
          w_be_n_nxt    = '0;
          w_dq_oe_nxt   = 1'b0;
        end else if (avs_write && (avs_byteenable != '0)) begin
          w_addr_nxt    = avs_address;
          w_dq_out_nxt  = avs_writedata;
          w_be_nxt      = avs_byteenable;
          w_last_op_nxt = c_op_write;
          if (c_turn_en && (r_last_op == c_op_read)) begin
            // Let the SRAM release DQ before the bridge starts driving it.
            w_state_nxt = S_TURN;
            w_cnt_nxt   = c_turn_init;
          end else begin
            w_state_nxt = S_WR;
            w_cnt_nxt   = c_wr_wait;
            w_ce_n_nxt  = 1'b0;
            w_we_n_nxt  = 1'b0;
            w_oe_n_nxt  = 1'b1;
            w_dq_oe_nxt = 1'b1;
            w_be_n_nxt  = ~avs_byteenable;
          end
        end
      end

      S_TURN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_WR;
          w_cnt_nxt   = c_wr_wait;
          w_ce_n_nxt  = 1'b0;
          w_we_n_nxt  = 1'b0;
          w_oe_n_nxt  = 1'b1;
          w_dq_oe_nxt = 1'b1;
          w_be_n_nxt  = ~r_be;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_RD: begin
        if (r_cnt == 4'd0) begin
          // Last strobe cycle: capture DQ and release the bus.
          w_rdata_nxt  = sram_dq_in;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
          w_ce_n_nxt   = 1'b1;
          w_oe_n_nxt   = 1'b1;
          w_be_n_nxt   = '1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_WR: begin
        if (r_cnt == 4'd0) begin
          // WE_N rises while CE_N and DQ stay put to meet data hold.
          w_state_nxt = S_WR_HOLD;
          w_we_n_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_WR_HOLD: begin
        w_state_nxt = S_IDLE;
        w_ce_n_nxt  = 1'b1;
        w_dq_oe_nxt = 1'b0;
        w_be_n_nxt  = '1;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_dq_oe_nxt = 1'b0;
        w_be_n_nxt  = '1;
      end
    endcase
  end

  assign avs_waitrequest   = (r_state != S_IDLE) || !reset_reset_n;
  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign sram_addr         = r_addr;
  assign sram_dq_out       = r_dq_out;
  assign sram_dq_oe        = r_dq_oe;
  assign sram_be_n         = r_be_n;
  assign sram_ce_n         = r_ce_n;
  assign sram_oe_n         = r_oe_n;
  assign sram_we_n         = r_we_n;
  assign sram_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bridge_p
//  Description : Self-checking bench for sram_bridge_p. Four instances cover
//                the default configuration (with a small SRAM model) and
//                several wait-state / turnaround / width configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bridge_p;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Per-instance stimulus (index 0: 16-bit default, 1..3: 32-bit variants)
  logic        rd_a   [4];
  logic        wr_a   [4];
  logic [19:0] addr_a [4];
  logic [31:0] wdata_a[4];
  logic [3:0]  be_a   [4];

  wire         waitreq_a[4];
  wire         rvalid_a [4];
  wire  [31:0] rdata_a  [4];
  wire  [19:0] saddr_a  [4];
  wire  [31:0] dqout_a  [4];
  wire         dqoe_a   [4];
  wire  [3:0]  be_n_a   [4];
  wire         ce_n_a   [4];
  wire         oe_n_a   [4];
  wire         we_n_a   [4];
  wire         err_a    [4];

  wire [15:0] a_rdata, a_dqout, a_dqin;
  wire [1:0]  a_be_n;
  wire [31:0] b_dqin, c_dqin, d_dqin;

  assign rdata_a[0] = {16'h0, a_rdata};
  assign dqout_a[0] = {16'h0, a_dqout};
  assign be_n_a[0]  = {2'b11, a_be_n};

  // Small SRAM model for the default instance (256 words by address LSBs).
  logic [15:0] mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
    end else if (!ce_n_a[0] && !we_n_a[0] && dqoe_a[0]) begin
      if (!a_be_n[0]) mem[saddr_a[0][7:0]][7:0]  <= a_dqout[7:0];
      if (!a_be_n[1]) mem[saddr_a[0][7:0]][15:8] <= a_dqout[15:8];
    end
  end
  assign a_dqin = (!ce_n_a[0] && !oe_n_a[0]) ? mem[saddr_a[0][7:0]] : 16'hDEAD;

  // Fixed read patterns for the other instances, only while OE_N is low.
  assign b_dqin = !oe_n_a[1] ? 32'hCAFE_F00D : 32'h0;
  assign c_dqin = !oe_n_a[2] ? 32'h1357_9BDF : 32'h0;
  assign d_dqin = !oe_n_a[3] ? 32'h2468_ACE0 : 32'h0;

  sram_bridge_p u_dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr_a[0]), .avs_read(rd_a[0]), .avs_write(wr_a[0]),
    .avs_writedata(wdata_a[0][15:0]), .avs_byteenable(be_a[0][1:0]),
    .avs_waitrequest(waitreq_a[0]), .avs_readdata(a_rdata), .avs_readdatavalid(rvalid_a[0]),
    .sram_addr(saddr_a[0]), .sram_dq_in(a_dqin), .sram_dq_out(a_dqout), .sram_dq_oe(dqoe_a[0]),
    .sram_be_n(a_be_n), .sram_ce_n(ce_n_a[0]), .sram_oe_n(oe_n_a[0]), .sram_we_n(we_n_a[0]),
    .sram_err(err_a[0])
  );

  sram_bridge_p #(.DATA_W(32), .ADDR_W(20), .RD_WAIT(3), .WR_WAIT(7), .TURN_CYCLES(2)) u_dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr_a[1]), .avs_read(rd_a[1]), .avs_write(wr_a[1]),
    .avs_writedata(wdata_a[1]), .avs_byteenable(be_a[1]),
    .avs_waitrequest(waitreq_a[1]), .avs_readdata(rdata_a[1]), .avs_readdatavalid(rvalid_a[1]),
    .sram_addr(saddr_a[1]), .sram_dq_in(b_dqin), .sram_dq_out(dqout_a[1]), .sram_dq_oe(dqoe_a[1]),
    .sram_be_n(be_n_a[1]), .sram_ce_n(ce_n_a[1]), .sram_oe_n(oe_n_a[1]), .sram_we_n(we_n_a[1]),
    .sram_err(err_a[1])
  );

  sram_bridge_p #(.DATA_W(32), .ADDR_W(20), .RD_WAIT(0), .WR_WAIT(0), .TURN_CYCLES(0)) u_dut_c (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr_a[2]), .avs_read(rd_a[2]), .avs_write(wr_a[2]),
    .avs_writedata(wdata_a[2]), .avs_byteenable(be_a[2]),
    .avs_waitrequest(waitreq_a[2]), .avs_readdata(rdata_a[2]), .avs_readdatavalid(rvalid_a[2]),
    .sram_addr(saddr_a[2]), .sram_dq_in(c_dqin), .sram_dq_out(dqout_a[2]), .sram_dq_oe(dqoe_a[2]),
    .sram_be_n(be_n_a[2]), .sram_ce_n(ce_n_a[2]), .sram_oe_n(oe_n_a[2]), .sram_we_n(we_n_a[2]),
    .sram_err(err_a[2])
  );

  sram_bridge_p #(.DATA_W(32), .ADDR_W(20), .RD_WAIT(15), .WR_WAIT(7), .TURN_CYCLES(0)) u_dut_d (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr_a[3]), .avs_read(rd_a[3]), .avs_write(wr_a[3]),
    .avs_writedata(wdata_a[3]), .avs_byteenable(be_a[3]),
    .avs_waitrequest(waitreq_a[3]), .avs_readdata(rdata_a[3]), .avs_readdatavalid(rvalid_a[3]),
    .sram_addr(saddr_a[3]), .sram_dq_in(d_dqin), .sram_dq_out(dqout_a[3]), .sram_dq_oe(dqoe_a[3]),
    .sram_be_n(be_n_a[3]), .sram_ce_n(ce_n_a[3]), .sram_oe_n(oe_n_a[3]), .sram_we_n(we_n_a[3]),
    .sram_err(err_a[3])
  );

  // Cycle monitors: WE_N-low cycles, readdatavalid pulses, DQ/OE overlap.
  int         we_total[4] = '{default: 0};
  int         rv_total[4] = '{default: 0};
  int         overlap [4] = '{default: 0};
  logic [3:0] we_be_n [4] = '{default: 4'hF};

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!we_n_a[k]) begin
        we_total[k]++;
        we_be_n[k] = be_n_a[k];
      end
      if (rvalid_a[k]) rv_total[k]++;
      if (dqoe_a[k] && !oe_n_a[k]) overlap[k]++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command on instance k and measure its effect. Latency and busy
  // are cycle indices relative to the accept cycle T (T+1 is index 1).
  task automatic run_op(input int k, input logic rd, input logic wr,
                        input logic [19:0] addr, input logic [31:0] data, input logic [3:0] be,
                        output int lat, output logic [31:0] rdat, output int we_w,
                        output int busy, output int pre_we, output int rv);
    int guard, we0, rv0, e;
    bit seen_we;
    lat = -1; rdat = '0; we_w = 0; busy = -1; pre_we = 0; rv = 0; seen_we = 1'b0;
    guard = 0;
    while (waitreq_a[k] && guard < 200) begin step(); guard++; end
    if (waitreq_a[k]) begin
      checks++; errors++;
      $display("FAIL idle_wait[%0d]: waitrequest got 1, expected 0", k);
      return;
    end
    we0 = we_total[k];
    rv0 = rv_total[k];
    rd_a[k] = rd; wr_a[k] = wr; addr_a[k] = addr; wdata_a[k] = data; be_a[k] = be;
    step();
    e = cyc;
    rd_a[k] = 1'b0; wr_a[k] = 1'b0;
    for (guard = 0; guard < 200; guard++) begin
      if (!we_n_a[k]) seen_we = 1'b1;
      else if (!seen_we && waitreq_a[k] && ce_n_a[k] && oe_n_a[k] && !dqoe_a[k]) pre_we++;
      if (rvalid_a[k] && lat < 0) begin
        lat  = cyc - e + 1;
        rdat = rdata_a[k];
      end
      if (!waitreq_a[k]) begin
        busy = cyc - e + 1;
        break;
      end
      step();
    end
    if (busy < 0) begin
      checks++; errors++;
      $display("FAIL op_done[%0d]: still busy, expected return to idle", k);
    end
    we_w = we_total[k] - we0;
    rv   = rv_total[k] - rv0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [19:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    int          exp_lat;
    logic [15:0] exp_rdata;
    int          exp_we;
    int          exp_busy;
    int          exp_pre;
    int          exp_rv;
    logic        exp_err;
  } vec_t;

  vec_t vt[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, we_w, busy, pre, rv, rv0;
    logic [31:0] rdat;

    for (int k = 0; k < 4; k++) begin
      rd_a[k] = 1'b0; wr_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0; be_a[k] = '0;
    end

    //            rd    wr    addr      data      be     lat rdata     we busy pre rv err
    vt[0]  = '{1'b0, 1'b1, 20'h0ABCD, 16'h1234, 2'b11, -1, 16'h0000, 2, 4, 0, 0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 20'h0ABCD, 16'h0000, 2'b00,  3, 16'h1234, 0, 3, 0, 1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 20'h00010, 16'hBEEF, 2'b11, -1, 16'h0000, 2, 5, 1, 0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 20'h00010, 16'h55AA, 2'b01, -1, 16'h0000, 2, 4, 0, 0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 20'h00010, 16'h1100, 2'b10, -1, 16'h0000, 2, 4, 0, 0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b00,  3, 16'h11AA, 0, 3, 0, 1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 20'h0ABCD, 16'hFFFF, 2'b00, -1, 16'h0000, 0, 1, 0, 0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 20'h0ABCD, 16'h4321, 2'b11, -1, 16'h0000, 2, 5, 1, 0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 20'h0ABCD, 16'h0000, 2'b00,  3, 16'h4321, 0, 3, 0, 1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 20'h00010, 16'h0000, 2'b11,  3, 16'h11AA, 0, 3, 0, 1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b00,  3, 16'h11AA, 0, 3, 0, 1, 1'b1};

    // Reset state
    repeat (3) step();
    chk("rst.waitreq", waitreq_a[0], 1);
    chk("rst.ce_n",    ce_n_a[0], 1);
    chk("rst.oe_n",    oe_n_a[0], 1);
    chk("rst.we_n",    we_n_a[0], 1);
    chk("rst.be_n",    be_n_a[0], 4'hF);
    chk("rst.dq_oe",   dqoe_a[0], 0);
    rst_n = 1'b1;
    step();
    chk("rst.waitreq_rel", waitreq_a[0], 0);
    chk("rst.err",     err_a[0], 0);
    chk("rst.rvalid",  rvalid_a[0], 0);
    chk("rst.rdata",   rdata_a[0], 0);
    chk("rst.addr",    saddr_a[0], 0);
    chk("rst.dq_out",  dqout_a[0], 0);

    // Default instance, table-driven
    for (int i = 0; i < 11; i++) begin
      run_op(0, vt[i].rd, vt[i].wr, vt[i].addr, {16'h0, vt[i].data}, {2'b00, vt[i].be},
             lat, rdat, we_w, busy, pre, rv);
      chk($sformatf("v%0d.lat", i),  lat,  vt[i].exp_lat);
      chk($sformatf("v%0d.busy", i), busy, vt[i].exp_busy);
      chk($sformatf("v%0d.we", i),   we_w, vt[i].exp_we);
      chk($sformatf("v%0d.pre", i),  pre,  vt[i].exp_pre);
      chk($sformatf("v%0d.rv", i),   rv,   vt[i].exp_rv);
      chk($sformatf("v%0d.err", i),  err_a[0], vt[i].exp_err);
      if (vt[i].rd) chk($sformatf("v%0d.rdata", i), rdat, {16'h0, vt[i].exp_rdata});
    end

    // 32-bit, RD_WAIT=3, WR_WAIT=7, TURN_CYCLES=2
    run_op(1, 1'b0, 1'b1, 20'h00020, 32'hA5A5_5A5A, 4'b0101, lat, rdat, we_w, busy, pre, rv);
    chk("b.wr.we",   we_w, 8);
    chk("b.wr.busy", busy, 10);
    chk("b.wr.pre",  pre, 0);
    chk("b.wr.be_n", we_be_n[1], 4'b1010);
    run_op(1, 1'b0, 1'b1, 20'h00024, 32'h0, 4'b0000, lat, rdat, we_w, busy, pre, rv);
    chk("b.be0.busy", busy, 1);
    chk("b.be0.we",   we_w, 0);
    run_op(1, 1'b1, 1'b0, 20'h00020, 32'h0, 4'b0000, lat, rdat, we_w, busy, pre, rv);
    chk("b.rd.lat",   lat, 5);
    chk("b.rd.rdata", rdat, 32'hCAFE_F00D);
    chk("b.rd.rv",    rv, 1);
    run_op(1, 1'b0, 1'b1, 20'h00028, 32'h1234_5678, 4'b1111, lat, rdat, we_w, busy, pre, rv);
    chk("b.turn.pre",  pre, 2);
    chk("b.turn.busy", busy, 12);
    chk("b.turn.we",   we_w, 8);
    chk("b.turn.be_n", we_be_n[1], 4'b0000);
    chk("b.addr",      saddr_a[1], 20'h00028);
    chk("b.dq_out",    dqout_a[1], 32'h1234_5678);
    chk("b.err",       err_a[1], 0);

    // 32-bit, RD_WAIT=0, WR_WAIT=0, TURN_CYCLES=0
    run_op(2, 1'b1, 1'b0, 20'h00100, 32'h0, 4'b0000, lat, rdat, we_w, busy, pre, rv);
    chk("c.rd.lat",   lat, 2);
    chk("c.rd.rdata", rdat, 32'h1357_9BDF);
    run_op(2, 1'b0, 1'b1, 20'h00104, 32'h0F0F_0F0F, 4'b1111, lat, rdat, we_w, busy, pre, rv);
    chk("c.wr.pre",  pre, 0);
    chk("c.wr.busy", busy, 3);
    chk("c.wr.we",   we_w, 1);

    // 32-bit, RD_WAIT=15, WR_WAIT=7, TURN_CYCLES=0
    run_op(3, 1'b1, 1'b0, 20'hFFFFF, 32'h0, 4'b0000, lat, rdat, we_w, busy, pre, rv);
    chk("d.rd.lat",   lat, 17);
    chk("d.rd.rdata", rdat, 32'h2468_ACE0);
    chk("d.addr",     saddr_a[3], 20'hFFFFF);
    run_op(3, 1'b0, 1'b1, 20'h00040, 32'h0, 4'b1100, lat, rdat, we_w, busy, pre, rv);
    chk("d.wr.pre",  pre, 0);
    chk("d.wr.busy", busy, 10);
    chk("d.wr.we",   we_w, 8);
    chk("d.wr.be_n", we_be_n[3], 4'b0011);

    for (int k = 0; k < 4; k++) chk($sformatf("overlap[%0d]", k), overlap[k], 0);

    // Reset in the middle of a read on the default instance
    rd_a[0] = 1'b1; addr_a[0] = 20'h00010;
    step();
    rd_a[0] = 1'b0;
    chk("mid.in_rd", oe_n_a[0], 0);
    rv0 = rv_total[0];
    rst_n = 1'b0;
    #1;
    chk("mid.waitreq", waitreq_a[0], 1);
    chk("mid.ce_n",    ce_n_a[0], 1);
    chk("mid.oe_n",    oe_n_a[0], 1);
    chk("mid.dq_oe",   dqoe_a[0], 0);
    chk("mid.err",     err_a[0], 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("mid.no_rv",   rv_total[0] - rv0, 0);
    chk("mid.waitreq_rel", waitreq_a[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_bridge_p.md
Name: sram_bridge_p

Overview:
- Parametrised Avalon-MM slave bridging to asynchronous SRAM; next generation of the fixed 16-bit/20-bit SRAM port on the Nios system.
- Adds configurable data/address width and per-lane byte enables.
- Adds programmable read/write wait states and a read-to-write bus turnaround.
- Adds a sticky protocol-error flag.
- Sits between the interconnect and the board SRAM pins; the top level instantiates the DQ tristate buffer from sram_dq_out/sram_dq_oe.

Parameters:
DATA_W, 16, SRAM data width; multiple of 8, range 8..64; BE_W = DATA_W/8
ADDR_W, 20, SRAM word-address width
RD_WAIT, 1, extra read strobe cycles, 0..15
WR_WAIT, 1, extra WE_N-low cycles, 0..15
TURN_CYCLES, 1, idle cycles inserted between a read and a following write, 0..7

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  word address
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  DATA_W  write data
avs_byteenable  in  BE_W  write lane enables
avs_waitrequest  out  1  command not accepted this cycle
avs_readdata  out  DATA_W  read data
avs_readdatavalid  out  1  readdata valid, single-cycle pulse
sram_addr  out  ADDR_W  SRAM address
sram_dq_in  in  DATA_W  DQ pin input
sram_dq_out  out  DATA_W  DQ drive value
sram_dq_oe  out  1  DQ output enable
sram_be_n  out  BE_W  lane selects (LB_N/UB_N generalised)
sram_ce_n  out  1  chip enable
sram_oe_n  out  1  output enable
sram_we_n  out  1  write enable
sram_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, immediate): sram_ce_n/oe_n/we_n=1, sram_be_n all 1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, avs_readdata=0, avs_readdatavalid=0, sram_err=0, state=IDLE, last_op=WRITE.
- avs_waitrequest=1 while reset_reset_n=0.
- Reset mid-transaction abandons the transaction; no readdatavalid is issued afterwards.
- All sram_* outputs, readdata and readdatavalid are registered. avs_waitrequest = (state != IDLE) or reset active.
- Acceptance: a command is accepted in IDLE on the cycle read or write is high; address, data and byteenable are latched.
- States: IDLE, TURN, RD, WR, WR_HOLD. Wait counter is 4 bits.
- Read accepted at cycle T:
  - RD occupies T+1..T+1+RD_WAIT with ce_n=0, oe_n=0, be_n=0, dq_oe=0.
  - sram_dq_in is sampled at the end of the last RD cycle.
  - avs_readdatavalid=1 and readdata valid in cycle T+RD_WAIT+2, which is IDLE again.
  - Back-to-back read: the next command can be accepted at T+RD_WAIT+2.
- Write accepted at T, previous op a write (or TURN_CYCLES=0):
  - WR occupies T+1..T+1+WR_WAIT with ce_n=0, we_n=0, oe_n=1, dq_oe=1, be_n=~byteenable.
  - WR_HOLD at T+WR_WAIT+2: we_n=1, ce_n=0, dq still driven.
  - IDLE at T+WR_WAIT+3 with dq_oe=0.
- Write accepted with last_op=READ and TURN_CYCLES>0: TURN for TURN_CYCLES cycles (all strobes inactive, dq_oe=0), then WR as above.
- Write with byteenable==0: accepted, no SRAM cycle, state stays IDLE, last_op unchanged.
- read and write both high in IDLE: treated as a read, the write is discarded, sram_err set to 1. sram_err clears only on reset.
- Requests while waitrequest=1 are ignored; the master must hold them.
- Address wrap-around: none; sram_addr is the latched avs_address verbatim.
- Invariant: sram_dq_oe=1 and sram_oe_n=0 are never true in the same cycle.

Test Plan:
- Reset: assert reset_reset_n=0 mid-RD -> strobes high, dq_oe=0, waitrequest=1 immediately; after release no readdatavalid and waitrequest=0.
- Single write then read, defaults: write addr 0x0ABCD, data 0x1234, be=2'b11 -> we_n low for 2 cycles, IDLE at T+4. Read addr 0x0ABCD with model returning 0x1234 -> readdatavalid at T+3 with 0x1234, no TURN.
- Byte lanes, DATA_W=32: write be=4'b0101 -> sram_be_n=4'b1010 during WR. Write be=0 -> no we_n pulse, waitrequest stays low.
- Read followed by write, TURN_CYCLES=2: exactly 2 cycles with all strobes high and dq_oe=0 between readdatavalid and first we_n=0. Checker confirms dq_oe and !oe_n never overlap.
- Wait-state sweep, RD_WAIT in {0,3,15} and WR_WAIT in {0,7}: read latency = RD_WAIT+2 cycles; we_n low width = WR_WAIT+1 cycles.
- Protocol error: read=1 and write=1 at addr 0x00010 -> read performed, SRAM contents unchanged, sram_err=1 and held until reset.
